// File: rtl/load_align_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_ctrl_if
//  Description : Request / memory-read / response bundle for the load
//                alignment sequencer. The slave modport is the sequencer's
//                view; the master modport is the CPU + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_align_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // Load request from the CPU load/store stage
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_signed;
  // Word-aligned read command and response toward data memory
  logic                  mem_rd_valid;
  logic                  mem_rd_ready;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rsp_valid;
  logic [31:0]           mem_rsp_data;
  // Aligned, extended result back to the CPU
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_split;

  modport slave (
    input  req_valid, req_addr, req_size, req_signed,
    output req_ready,
    output mem_rd_valid, mem_rd_addr,
    input  mem_rd_ready, mem_rsp_valid, mem_rsp_data,
    output rsp_valid, rsp_data, rsp_split,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_size, req_signed,
    input  req_ready,
    input  mem_rd_valid, mem_rd_addr,
    output mem_rd_ready, mem_rsp_valid, mem_rsp_data,
    input  rsp_valid, rsp_data, rsp_split,
    output rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/load_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_ctrl
//  Description : Load sequencer. Accepts one load (address, size, sign),
//                issues one or two word-aligned memory reads, then aligns
//                and zero/sign-extends the selected bytes (little-endian)
//                into a registered 32-bit result.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              arst,
  load_align_ctrl_if.slave  bus
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_RD0  = 3'd1;
  localparam logic [2:0] c_WT0  = 3'd2;
  localparam logic [2:0] c_RD1  = 3'd3;
  localparam logic [2:0] c_WT1  = 3'd4;
  localparam logic [2:0] c_RESP = 3'd5;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_split;
  logic [31:0]           r_w0;
  logic [31:0]           r_rsp_data;
  logic                  r_rsp_split;

  logic                  w_split;
  logic [ADDR_WIDTH-1:0] w_word0_addr;
  logic [31:0]           w_lo;
  logic [31:0]           w_hi;
  logic [63:0]           w_cat;
  logic [31:0]           w_v;
  logic [31:0]           w_result;

  // Split detection on the incoming request: access crosses a word boundary
  always_comb begin
    w_split = ((bus.req_size == c_SZ_HALF) && (bus.req_addr[1:0] == 2'd3)) ||
              (bus.req_size[1] && (bus.req_addr[1:0] != 2'd0));
  end

  // Result alignment: in WT0 the fresh word is the low word; in WT1 the
  // buffered first word is low and the fresh word supplies the upper bytes
  always_comb begin
    w_word0_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    w_lo  = (r_state == c_WT1) ? r_w0 : bus.mem_rsp_data;
    w_hi  = (r_state == c_WT1) ? bus.mem_rsp_data : 32'd0;
    w_cat = {w_hi, w_lo} >> {r_addr[1:0], 3'b000};
    w_v   = w_cat[31:0];
    if (r_size == c_SZ_BYTE) begin
      w_result = {{24{r_signed & w_v[7]}}, w_v[7:0]};
    end else if (r_size == c_SZ_HALF) begin
      w_result = {{16{r_signed & w_v[15]}}, w_v[15:0]};
    end else begin
      w_result = w_v;
    end
  end

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; responses outside WT0/WT1 are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (bus.req_valid)     w_state_nxt = c_RD0;
      c_RD0:  if (bus.mem_rd_ready)  w_state_nxt = c_WT0;
      c_WT0:  if (bus.mem_rsp_valid) w_state_nxt = r_split ? c_RD1 : c_RESP;
      c_RD1:  if (bus.mem_rd_ready)  w_state_nxt = c_WT1;
      c_WT1:  if (bus.mem_rsp_valid) w_state_nxt = c_RESP;
      c_RESP: if (bus.rsp_ready)     w_state_nxt = c_IDLE;
      default:                       w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decoded from state; read address is 0 whenever no read is issued
  always_comb begin
    bus.req_ready    = (r_state == c_IDLE);
    bus.mem_rd_valid = (r_state == c_RD0) || (r_state == c_RD1);
    bus.mem_rd_addr  = '0;
    if (r_state == c_RD0) begin
      bus.mem_rd_addr = w_word0_addr;
    end else if (r_state == c_RD1) begin
      bus.mem_rd_addr = w_word0_addr + ADDR_WIDTH'(4);
    end
    bus.rsp_valid = (r_state == c_RESP);
    bus.rsp_data  = r_rsp_data;
    bus.rsp_split = r_rsp_split;
  end

  // Request latch, first-word buffer and registered result (written only
  // when the final word of the load is captured)
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_split     <= 1'b0;
      r_w0        <= '0;
      r_rsp_data  <= '0;
      r_rsp_split <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && bus.req_valid) begin
        r_addr   <= bus.req_addr;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_split  <= w_split;
      end
      if ((r_state == c_WT0) && bus.mem_rsp_valid) begin
        r_w0 <= bus.mem_rsp_data;
        if (!r_split) begin
          r_rsp_data  <= w_result;
          r_rsp_split <= 1'b0;
        end
      end
      if ((r_state == c_WT1) && bus.mem_rsp_valid) begin
        r_rsp_data  <= w_result;
        r_rsp_split <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_align_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_align_ctrl
//  Description : Directed self-checking bench for load_align_ctrl. Inputs
//                are driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_align_ctrl;

  localparam int ADDR_WIDTH = 32;

  logic clk;
  logic arst;
  int   n_err;
  int   n_chk;

  load_align_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  load_align_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h788E_FD0C;
      32'h0000_0104: return 32'h1122_3344;
      32'hFFFF_FFFC: return 32'hAABB_CCDD;
      32'h0000_0000: return 32'h5566_7788;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic issue_req(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    @(negedge clk);
    check_eq("req_ready idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  // Serve one read command: optional ready stall, then optional response delay
  task automatic serve_read(input logic [31:0] exp_addr, input int rd_stall,
                            input int rsp_delay, input bit do_rsp);
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (bus.mem_rd_valid) seen = 1;
      else @(negedge clk);
    end
    check_eq("rd_valid seen", 32'(seen), 32'd1);
    check_eq("rd_addr", bus.mem_rd_addr, exp_addr);
    for (int i = 0; i < rd_stall; i++) begin
      @(negedge clk);
      check_eq("rd_valid held", 32'(bus.mem_rd_valid), 32'd1);
      check_eq("rd_addr held", bus.mem_rd_addr, exp_addr);
    end
    bus.mem_rd_ready = 1'b1;
    @(negedge clk);
    bus.mem_rd_ready = 1'b0;
    for (int i = 0; i < rsp_delay; i++) begin
      check_eq("wait no rd_valid", 32'(bus.mem_rd_valid), 32'd0);
      check_eq("wait no rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    if (do_rsp) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_word(exp_addr);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 32'h0BAD_0BAD;
    end
  endtask

  // Result must be valid right after the final capture, held under stall
  task automatic take_resp(input logic [31:0] exp, input logic exp_split, input int rr_stall);
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("rsp_data", bus.rsp_data, exp);
    check_eq("rsp_split", 32'(bus.rsp_split), 32'(exp_split));
    for (int i = 0; i < rr_stall; i++) begin
      @(negedge clk);
      check_eq("rsp_valid held", 32'(bus.rsp_valid), 32'd1);
      check_eq("rsp_data held", bus.rsp_data, exp);
      check_eq("req_ready low in resp", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_valid dropped", 32'(bus.rsp_valid), 32'd0);
    check_eq("req_ready back", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] exp, input logic split,
                         input int rd_stall, input int rsp_delay, input int rr_stall);
    logic [31:0] w0;
    w0 = {addr[31:2], 2'b00};
    issue_req(addr, size, sgn);
    serve_read(w0, rd_stall, rsp_delay, 1'b1);
    if (split) serve_read(w0 + 32'd4, 0, 0, 1'b1);
    take_resp(exp, split, rr_stall);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.req_size      = 2'd0;
    bus.req_signed    = 1'b0;
    bus.mem_rd_ready  = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.rsp_ready     = 1'b0;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("reset mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
    check_eq("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("reset rsp_data", bus.rsp_data, 32'd0);
    arst = 1'b0;

    // Byte loads
    do_load(32'h100, 2'd0, 1'b0, 32'h0000_000C, 1'b0, 0, 0, 0);
    do_load(32'h101, 2'd0, 1'b1, 32'hFFFF_FFFD, 1'b0, 0, 0, 0);
    do_load(32'h102, 2'd0, 1'b1, 32'hFFFF_FF8E, 1'b0, 0, 0, 0);
    do_load(32'h103, 2'd0, 1'b1, 32'h0000_0078, 1'b0, 0, 0, 0);
    // Halfword and word loads
    do_load(32'h100, 2'd1, 1'b1, 32'hFFFF_FD0C, 1'b0, 0, 0, 0);
    do_load(32'h100, 2'd1, 1'b0, 32'h0000_FD0C, 1'b0, 0, 0, 0);
    do_load(32'h102, 2'd1, 1'b1, 32'h0000_788E, 1'b0, 0, 0, 0);
    do_load(32'h100, 2'd2, 1'b0, 32'h788E_FD0C, 1'b0, 0, 0, 0);
    do_load(32'h100, 2'd3, 1'b1, 32'h788E_FD0C, 1'b0, 0, 0, 0);
    // Split loads
    do_load(32'h102, 2'd2, 1'b0, 32'h3344_788E, 1'b1, 0, 0, 0);
    do_load(32'h103, 2'd1, 1'b1, 32'h0000_4478, 1'b1, 0, 0, 0);
    // Backpressure: read-ready stall, response delay, result stall
    do_load(32'h101, 2'd0, 1'b1, 32'hFFFF_FFFD, 1'b0, 3, 4, 5);
    // Address wrap on the second read
    do_load(32'hFFFF_FFFE, 2'd2, 1'b0, 32'h7788_AABB, 1'b1, 0, 0, 0);

    // Spurious response while idle
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("spurious req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("spurious rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("spurious mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
    check_eq("spurious rsp_data", bus.rsp_data, 32'h7788_AABB);

    // Reset while waiting for the second word
    issue_req(32'h102, 2'd2, 1'b0);
    serve_read(32'h100, 0, 0, 1'b1);
    serve_read(32'h104, 0, 1, 1'b0);
    #2 arst = 1'b1;
    #1;
    check_eq("arst req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("arst mem_rd_valid", 32'(bus.mem_rd_valid), 32'd0);
    check_eq("arst mem_rd_addr", bus.mem_rd_addr, 32'd0);
    check_eq("arst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("arst rsp_data", bus.rsp_data, 32'd0);
    check_eq("arst rsp_split", 32'(bus.rsp_split), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1122_3344;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check_eq("late rsp req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("late rsp rsp_valid", 32'(bus.rsp_valid), 32'd0);
    do_load(32'h101, 2'd0, 1'b0, 32'h0000_00FD, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
